// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit AXI4-Lite master.
package lsu_pkg;

    // Access size encoding as presented by the pipeline.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    // Master FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // An access is misaligned when the address is not a multiple of its size.
    // Doubleword accesses are also rejected on a 32-bit bus.
    function automatic logic is_misaligned(
        input logic [2:0] addr_lo,
        input lsu_size_e  size,
        input logic       wide_bus
    );
        logic result;
        case (size)
            SZ_B:    result = 1'b0;
            SZ_H:    result = addr_lo[0];
            SZ_W:    result = |addr_lo[1:0];
            default: result = !wide_bus || (|addr_lo);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the LSB-justified pipeline view and the bus view:
// store data/strobe placement and load extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  lsu_size_e         size,
    input  logic              zero_ext,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata_out,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [OFF_W+2:0]  bit_shift;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] rdata_sh;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    assign bit_shift = {off, 3'b000};
    assign wdata_out = wdata << bit_shift;
    assign wstrb     = strb_base << off;
    assign rdata_sh  = rdata >> bit_shift;

    // Strobe pattern for the access size before it is moved to its lane.
    always_comb begin
        case (size)
            SZ_B:    strb_base = STRB_W'(8'h01);
            SZ_H:    strb_base = STRB_W'(8'h03);
            SZ_W:    strb_base = STRB_W'(8'h0F);
            default: strb_base = STRB_W'(8'hFF);
        endcase
    end

    // Keep the accessed bytes and fill the rest with the sign (or zero).
    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            SZ_B: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = rdata_sh[7];
            end
            SZ_H: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = rdata_sh[15];
            end
            SZ_W: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = rdata_sh[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        rdata_ext = (rdata_sh & keep_mask)
                  | ({DATA_W{sign_bit & ~zero_ext}} & ~keep_mask);
    end

endmodule

// File: rtl/lsu_axil_master.sv
// Load/store unit: one pipeline request at a time, translated into a single
// AXI4-Lite read or write, with a one-cycle completion pulse back.
module lsu_axil_master
    import lsu_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    localparam int OFF_W = $clog2(STRB_W);

    lsu_state_e        state_reg;
    logic              misalign_pend_reg;
    logic [OFF_W-1:0]  off_reg;
    lsu_size_e         size_reg;
    logic              zero_ext_reg;
    logic              aw_done_reg;
    logic              w_done_reg;

    logic [ADDR_W-1:0] m_araddr_reg;
    logic              m_arvalid_reg;
    logic              m_rready_reg;
    logic [ADDR_W-1:0] m_awaddr_reg;
    logic              m_awvalid_reg;
    logic [DATA_W-1:0] m_wdata_reg;
    logic [STRB_W-1:0] m_wstrb_reg;
    logic              m_wvalid_reg;
    logic              m_bready_reg;

    logic              resp_valid_reg;
    logic [DATA_W-1:0] resp_rdata_reg;
    logic              resp_err_reg;
    logic              resp_misalign_reg;

    logic              accept;
    logic              req_misalign;
    logic              aw_fire;
    logic              w_fire;
    logic              aw_ok;
    logic              w_ok;

    logic [OFF_W-1:0]  align_off;
    lsu_size_e         align_size;
    logic              align_zext;
    logic [DATA_W-1:0] align_wdata;
    logic [STRB_W-1:0] align_wstrb;
    logic [DATA_W-1:0] align_rdata;

    // A misaligned request spends one cycle parked in IDLE (not ready) before
    // its response, giving it a fixed two-cycle turnaround with no bus traffic.
    assign req_ready    = (state_reg == ST_IDLE) && !misalign_pend_reg;
    assign accept       = req_valid && req_ready;
    assign req_misalign = is_misaligned(req_addr[2:0], lsu_size_e'(req_size), DATA_W == 64);

    assign aw_fire = m_awvalid_reg && m_awready;
    assign w_fire  = m_wvalid_reg && m_wready;
    assign aw_ok   = aw_done_reg || aw_fire;
    assign w_ok    = w_done_reg || w_fire;

    // Lane logic sees the live request while idle (to build the store beat)
    // and the captured request afterwards (to extract load data).
    always_comb begin
        align_off  = off_reg;
        align_size = size_reg;
        align_zext = zero_ext_reg;
        if (state_reg == ST_IDLE) begin
            align_off  = req_addr[OFF_W-1:0];
            align_size = lsu_size_e'(req_size);
            align_zext = req_unsigned;
        end
    end

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .off       (align_off),
        .size      (align_size),
        .zero_ext  (align_zext),
        .wdata     (req_wdata),
        .rdata     (m_rdata),
        .wdata_out (align_wdata),
        .wstrb     (align_wstrb),
        .rdata_ext (align_rdata)
    );

    // Master FSM with registered bus handshakes and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            misalign_pend_reg <= 1'b0;
            off_reg           <= '0;
            size_reg          <= SZ_B;
            zero_ext_reg      <= 1'b0;
            aw_done_reg       <= 1'b0;
            w_done_reg        <= 1'b0;
            m_araddr_reg      <= '0;
            m_arvalid_reg     <= 1'b0;
            m_rready_reg      <= 1'b0;
            m_awaddr_reg      <= '0;
            m_awvalid_reg     <= 1'b0;
            m_wdata_reg       <= '0;
            m_wstrb_reg       <= '0;
            m_wvalid_reg      <= 1'b0;
            m_bready_reg      <= 1'b0;
            resp_valid_reg    <= 1'b0;
            resp_rdata_reg    <= '0;
            resp_err_reg      <= 1'b0;
            resp_misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (misalign_pend_reg) begin
                        misalign_pend_reg <= 1'b0;
                        state_reg         <= ST_RESP;
                        resp_valid_reg    <= 1'b1;
                        resp_err_reg      <= 1'b1;
                        resp_misalign_reg <= 1'b1;
                        resp_rdata_reg    <= '0;
                    end else if (accept) begin
                        off_reg      <= req_addr[OFF_W-1:0];
                        size_reg     <= lsu_size_e'(req_size);
                        zero_ext_reg <= req_unsigned;
                        m_araddr_reg <= req_addr;
                        m_awaddr_reg <= req_addr;
                        m_wdata_reg  <= align_wdata;
                        m_wstrb_reg  <= align_wstrb;
                        if (req_misalign) begin
                            misalign_pend_reg <= 1'b1;
                        end else if (req_write) begin
                            state_reg     <= ST_WR_REQ;
                            m_awvalid_reg <= 1'b1;
                            m_wvalid_reg  <= 1'b1;
                            aw_done_reg   <= 1'b0;
                            w_done_reg    <= 1'b0;
                        end else begin
                            state_reg     <= ST_RD_ADDR;
                            m_arvalid_reg <= 1'b1;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (m_arready) begin
                        m_arvalid_reg <= 1'b0;
                        m_rready_reg  <= 1'b1;
                        state_reg     <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_rvalid) begin
                        m_rready_reg      <= 1'b0;
                        state_reg         <= ST_RESP;
                        resp_valid_reg    <= 1'b1;
                        resp_misalign_reg <= 1'b0;
                        resp_err_reg      <= (m_rresp != AXI_RESP_OKAY);
                        resp_rdata_reg    <= (m_rresp == AXI_RESP_OKAY) ? align_rdata : '0;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_fire) begin
                        m_awvalid_reg <= 1'b0;
                        aw_done_reg   <= 1'b1;
                    end
                    if (w_fire) begin
                        m_wvalid_reg <= 1'b0;
                        w_done_reg   <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        m_bready_reg <= 1'b1;
                        state_reg    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready_reg      <= 1'b0;
                        state_reg         <= ST_RESP;
                        resp_valid_reg    <= 1'b1;
                        resp_misalign_reg <= 1'b0;
                        resp_err_reg      <= (m_bresp != AXI_RESP_OKAY);
                        resp_rdata_reg    <= '0;
                    end
                end
                ST_RESP: begin
                    resp_valid_reg    <= 1'b0;
                    resp_err_reg      <= 1'b0;
                    resp_misalign_reg <= 1'b0;
                    resp_rdata_reg    <= '0;
                    state_reg         <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_araddr      = m_araddr_reg;
    assign m_arvalid     = m_arvalid_reg;
    assign m_rready      = m_rready_reg;
    assign m_awaddr      = m_awaddr_reg;
    assign m_awvalid     = m_awvalid_reg;
    assign m_wdata       = m_wdata_reg;
    assign m_wstrb       = m_wstrb_reg;
    assign m_wvalid      = m_wvalid_reg;
    assign m_bready      = m_bready_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_rdata    = resp_rdata_reg;
    assign resp_err      = resp_err_reg;
    assign resp_misalign = resp_misalign_reg;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Bench for lsu_axil_master (32- and 64-bit instances) and lsu_lane_align.
module tb_lsu_axil_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Shared request and slave-side stimulus; each DUT has its own req_valid.
    logic        req_valid_a, req_valid_b;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;

    // 32-bit instance outputs
    logic        a_req_ready, a_resp_valid, a_resp_err, a_resp_misalign;
    logic [31:0] a_resp_rdata, a_araddr, a_awaddr, a_wdata;
    logic        a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready;
    logic [3:0]  a_wstrb;
    // 64-bit instance outputs
    logic        b_req_ready, b_resp_valid, b_resp_err, b_resp_misalign;
    logic [63:0] b_resp_rdata, b_wdata;
    logic [31:0] b_araddr, b_awaddr;
    logic        b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
    logic [7:0]  b_wstrb;

    lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(a_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .resp_misalign(a_resp_misalign),
        .m_araddr(a_araddr), .m_arvalid(a_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata[31:0]), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(a_rready),
        .m_awaddr(a_awaddr), .m_awvalid(a_awvalid), .m_awready(m_awready),
        .m_wdata(a_wdata), .m_wstrb(a_wstrb), .m_wvalid(a_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(a_bready)
    );

    lsu_axil_master #(.ADDR_W(32), .DATA_W(64)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(b_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .resp_misalign(b_resp_misalign),
        .m_araddr(b_araddr), .m_arvalid(b_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(b_rready),
        .m_awaddr(b_awaddr), .m_awvalid(b_awvalid), .m_awready(m_awready),
        .m_wdata(b_wdata), .m_wstrb(b_wstrb), .m_wvalid(b_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(b_bready)
    );

    // Observation mux: sel picks which instance the slave model talks to.
    logic        sel;
    logic        o_req_ready, o_resp_valid, o_resp_err, o_resp_misalign;
    logic [63:0] o_resp_rdata, o_wdata;
    logic [31:0] o_araddr, o_awaddr;
    logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic [7:0]  o_wstrb;
    always_comb begin
        o_req_ready     = sel ? b_req_ready     : a_req_ready;
        o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
        o_resp_err      = sel ? b_resp_err      : a_resp_err;
        o_resp_misalign = sel ? b_resp_misalign : a_resp_misalign;
        o_resp_rdata    = sel ? b_resp_rdata    : {32'h0, a_resp_rdata};
        o_araddr        = sel ? b_araddr        : a_araddr;
        o_awaddr        = sel ? b_awaddr        : a_awaddr;
        o_wdata         = sel ? b_wdata         : {32'h0, a_wdata};
        o_wstrb         = sel ? b_wstrb         : {4'h0, a_wstrb};
        o_arvalid       = sel ? b_arvalid       : a_arvalid;
        o_rready        = sel ? b_rready        : a_rready;
        o_awvalid       = sel ? b_awvalid       : a_awvalid;
        o_wvalid        = sel ? b_wvalid        : a_wvalid;
        o_bready        = sel ? b_bready        : a_bready;
    end

    // Standalone lane-align instance for the vector table
    logic [1:0]  la_off, la_size;
    logic        la_zext;
    logic [31:0] la_wdata, la_rdata, la_wdata_out, la_rdata_ext;
    logic [3:0]  la_wstrb;
    lsu_lane_align #(.DATA_W(32)) u_align (
        .off(la_off), .size(lsu_size_e'(la_size)), .zero_ext(la_zext),
        .wdata(la_wdata), .rdata(la_rdata),
        .wdata_out(la_wdata_out), .wstrb(la_wstrb), .rdata_ext(la_rdata_ext)
    );

    typedef struct {
        logic [1:0]  off;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    // Per-transaction observations
    int          r_lat, r_pulses, r_ar_cycles, r_aw_cycles, r_w_cycles;
    logic        r_err, r_mis, r_ready_after;
    logic [63:0] r_rdata, r_wdata;
    logic [31:0] r_araddr, r_awaddr;
    logic [7:0]  r_wstrb;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_slave;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
    endtask

    // Issue one request and act as a responsive slave until the pulse is seen.
    task automatic run_txn(input string name, input logic use64, input logic wr,
                           input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input logic [1:0] xresp, input int ar_dly, input int aw_dly,
                           input int w_dly);
        int resp_n;
        sel = use64;
        #0;
        chk({name, ".req_ready"}, 64'(o_req_ready), 64'(1));
        req_write = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (use64) req_valid_b = 1; else req_valid_a = 1;
        tick();
        req_valid_a = 0; req_valid_b = 0;
        // Later request-field changes must not matter.
        req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_size = ~size; req_unsigned = ~uns;
        r_lat = -1; r_pulses = 0; r_ar_cycles = 0; r_aw_cycles = 0; r_w_cycles = 0;
        r_err = 0; r_mis = 0; r_ready_after = 0; r_rdata = '0; r_wdata = '0;
        r_araddr = '0; r_awaddr = '0; r_wstrb = '0;
        resp_n = -1;
        for (int n = 1; n <= 60; n++) begin
            if (o_resp_valid) begin
                r_pulses++;
                if (resp_n < 0) begin
                    resp_n = n; r_lat = n; r_rdata = o_resp_rdata;
                    r_err = o_resp_err; r_mis = o_resp_misalign;
                end
            end
            if (resp_n >= 0 && n == resp_n + 1) r_ready_after = o_req_ready;
            if (resp_n >= 0 && n == resp_n + 2) break;
            if (o_arvalid) begin
                r_ar_cycles++; r_araddr = o_araddr; m_arready = (r_ar_cycles > ar_dly);
            end else m_arready = 0;
            if (o_awvalid) begin
                r_aw_cycles++; r_awaddr = o_awaddr; m_awready = (r_aw_cycles > aw_dly);
            end else m_awready = 0;
            if (o_wvalid) begin
                r_w_cycles++; r_wdata = o_wdata; r_wstrb = o_wstrb; m_wready = (r_w_cycles > w_dly);
            end else m_wready = 0;
            m_rvalid = o_rready; m_rdata = rdata; m_rresp = xresp;
            m_bvalid = o_bready; m_bresp = xresp;
            tick();
        end
        clear_slave();
        if (resp_n < 0) chk({name, ".timeout"}, 64'(0), 64'(1));
        chk({name, ".pulses"}, 64'(r_pulses), 64'(1));
        chk({name, ".ready_after"}, 64'(r_ready_after), 64'(1));
        $display("txn %s lat=%0d rdata=%h err=%b mis=%b ar=%0d aw=%0d w=%0d",
                 name, r_lat, r_rdata, r_err, r_mis, r_ar_cycles, r_aw_cycles, r_w_cycles);
    endtask

    initial begin
        int quiet_pulses;
        rst = 1; sel = 0; req_valid_a = 0; req_valid_b = 0;
        req_write = 0; req_size = 0; req_unsigned = 0; req_addr = '0; req_wdata = '0;
        clear_slave();

        // ---- lane-align vector table ----
        vecs[0] = '{2'd3, 2'd0, 1'b0, 32'h0000_00AB, 32'h8012_3456, 32'hAB00_0000, 4'b1000, 32'hFFFF_FF80};
        vecs[1] = '{2'd3, 2'd0, 1'b1, 32'h0000_00AB, 32'h8012_3456, 32'hAB00_0000, 4'b1000, 32'h0000_0080};
        vecs[2] = '{2'd2, 2'd1, 1'b0, 32'h0000_1234, 32'h8001_5555, 32'h1234_0000, 4'b1100, 32'hFFFF_8001};
        vecs[3] = '{2'd2, 2'd1, 1'b1, 32'h0000_1234, 32'h8001_5555, 32'h1234_0000, 4'b1100, 32'h0000_8001};
        vecs[4] = '{2'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4'b1111, 32'hCAFE_F00D};
        vecs[5] = '{2'd1, 2'd0, 1'b0, 32'h0000_0055, 32'h0000_7F00, 32'h0000_5500, 4'b0010, 32'h0000_007F};
        vecs[6] = '{2'd0, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0000_FFFE, 32'h0000_ABCD, 4'b0011, 32'hFFFF_FFFE};
        vecs[7] = '{2'd0, 2'd0, 1'b1, 32'h0000_0011, 32'h0000_00FF, 32'h0000_0011, 4'b0001, 32'h0000_00FF};
        for (int i = 0; i < 8; i++) begin
            la_off = vecs[i].off; la_size = vecs[i].size; la_zext = vecs[i].zext;
            la_wdata = vecs[i].wdata; la_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d.wdata", i), 64'(la_wdata_out), 64'(vecs[i].exp_wdata));
            chk($sformatf("vec%0d.wstrb", i), 64'(la_wstrb), 64'(vecs[i].exp_wstrb));
            chk($sformatf("vec%0d.rdata", i), 64'(la_rdata_ext), 64'(vecs[i].exp_rdata));
            $display("vec %0d off=%0d size=%0d wdata=%h wstrb=%b rdata=%h",
                     i, la_off, la_size, la_wdata_out, la_wstrb, la_rdata_ext);
        end

        // ---- reset state ----
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst.req_ready", 64'(a_req_ready), 64'(1));
        chk("rst.valids", 64'({a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready}), 64'(0));
        chk("rst.resp", 64'({a_resp_valid, a_resp_err, a_resp_misalign}), 64'(0));
        chk("rst.resp_rdata", 64'(a_resp_rdata), 64'(0));
        chk("rst.addr_data", 64'({a_araddr, a_awaddr}), 64'(0));
        chk("rst.b_req_ready", 64'(b_req_ready), 64'(1));

        // ---- word load, zero-wait ----
        run_txn("lw", 0, 0, 2'd2, 0, 32'h8000_0004, '0, 64'hDEAD_BEEF, 2'b00, 0, 0, 0);
        chk("lw.araddr", 64'(r_araddr), 64'h8000_0004);
        chk("lw.lat", 64'(r_lat), 64'(3));
        chk("lw.rdata", r_rdata, 64'hDEAD_BEEF);
        chk("lw.err", 64'({r_err, r_mis}), 64'(0));
        chk("lw.no_aw", 64'(r_aw_cycles + r_w_cycles), 64'(0));

        // ---- byte loads, signed then unsigned ----
        run_txn("lb", 0, 0, 2'd0, 0, 32'h0000_1003, '0, 64'h8012_3456, 2'b00, 0, 0, 0);
        chk("lb.rdata", r_rdata, 64'hFFFF_FF80);
        chk("lb.lat", 64'(r_lat), 64'(3));
        run_txn("lbu", 0, 0, 2'd0, 1, 32'h0000_1003, '0, 64'h8012_3456, 2'b00, 0, 0, 0);
        chk("lbu.rdata", r_rdata, 64'h0000_0080);

        // ---- halfword store, awready delayed 3 cycles ----
        run_txn("sh", 0, 1, 2'd1, 0, 32'h0000_1002, 64'h1234, '0, 2'b00, 0, 3, 0);
        chk("sh.wdata", r_wdata, 64'h1234_0000);
        chk("sh.wstrb", 64'(r_wstrb), 64'b1100);
        chk("sh.awaddr", 64'(r_awaddr), 64'h0000_1002);
        chk("sh.w_cycles", 64'(r_w_cycles), 64'(1));
        chk("sh.aw_cycles", 64'(r_aw_cycles), 64'(4));
        chk("sh.lat", 64'(r_lat), 64'(6));
        chk("sh.resp", 64'({r_err, r_mis}), 64'(0));
        chk("sh.rdata", r_rdata, 64'(0));

        // ---- store with both readies in the same cycle, and w delayed ----
        run_txn("sw_both", 0, 1, 2'd2, 0, 32'h0000_2000, 64'hA5A5_5A5A, '0, 2'b00, 0, 0, 0);
        chk("sw_both.lat", 64'(r_lat), 64'(3));
        chk("sw_both.strb", 64'(r_wstrb), 64'hF);
        run_txn("sw_wdly", 0, 1, 2'd2, 0, 32'h0000_2004, 64'h1, '0, 2'b00, 0, 0, 2);
        chk("sw_wdly.lat", 64'(r_lat), 64'(5));
        chk("sw_wdly.cycles", 64'({r_aw_cycles[7:0], r_w_cycles[7:0]}), 64'h0103);

        // ---- misalignment ----
        run_txn("lw_mis", 0, 0, 2'd2, 0, 32'h0000_1001, '0, 64'h1234_5678, 2'b00, 0, 0, 0);
        chk("lw_mis.no_ar", 64'(r_ar_cycles), 64'(0));
        chk("lw_mis.lat", 64'(r_lat), 64'(2));
        chk("lw_mis.resp", 64'({r_err, r_mis}), 64'b11);
        chk("lw_mis.rdata", r_rdata, 64'(0));
        run_txn("sd32", 0, 1, 2'd3, 0, 32'h0000_1000, 64'h55, '0, 2'b00, 0, 0, 0);
        chk("sd32.no_bus", 64'(r_aw_cycles + r_w_cycles + r_ar_cycles), 64'(0));
        chk("sd32.lat", 64'(r_lat), 64'(2));
        chk("sd32.resp", 64'({r_err, r_mis}), 64'b11);

        // ---- bus errors ----
        run_txn("sw_slverr", 0, 1, 2'd2, 0, 32'h0000_3000, 64'h77, '0, 2'b10, 0, 0, 0);
        chk("sw_slverr.resp", 64'({r_err, r_mis}), 64'b10);
        chk("sw_slverr.lat", 64'(r_lat), 64'(3));
        run_txn("lw_decerr", 0, 0, 2'd2, 0, 32'h0000_3004, '0, 64'hFFFF_FFFF, 2'b11, 0, 0, 0);
        chk("lw_decerr.resp", 64'({r_err, r_mis}), 64'b10);
        chk("lw_decerr.rdata", r_rdata, 64'(0));

        // ---- reset while waiting in RD_DATA ----
        sel = 0;
        req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h0000_4000;
        m_arready = 1; req_valid_a = 1;
        tick();
        req_valid_a = 0;
        tick();
        m_arready = 0;
        chk("rst_mid.in_rd_data", 64'(o_rready), 64'(1));
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid.rready", 64'(o_rready), 64'(0));
        chk("rst_mid.req_ready", 64'(o_req_ready), 64'(1));
        quiet_pulses = 0;
        for (int n = 0; n < 4; n++) begin
            if (o_resp_valid) quiet_pulses++;
            tick();
        end
        chk("rst_mid.no_resp", 64'(quiet_pulses), 64'(0));
        $display("txn rst_mid rready=%b req_ready=%b pulses=%0d", o_rready, o_req_ready, quiet_pulses);

        // ---- 64-bit instance ----
        run_txn("ld64", 1, 0, 2'd3, 0, 32'h0000_0008, '0, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0);
        chk("ld64.rdata", r_rdata, 64'h0123_4567_89AB_CDEF);
        chk("ld64.resp", 64'({r_err, r_mis}), 64'(0));
        chk("ld64.lat", 64'(r_lat), 64'(3));
        run_txn("sd64", 1, 1, 2'd3, 0, 32'h0000_0008, 64'hFEDC_BA98_7654_3210, '0, 2'b00, 0, 0, 0);
        chk("sd64.wdata", r_wdata, 64'hFEDC_BA98_7654_3210);
        chk("sd64.wstrb", 64'(r_wstrb), 64'hFF);
        run_txn("lw64_hi", 1, 0, 2'd2, 0, 32'h0000_000C, '0, 64'h8000_0000_1111_1111, 2'b00, 0, 0, 0);
        chk("lw64_hi.rdata", r_rdata, 64'hFFFF_FFFF_8000_0000);
        run_txn("lwu64_hi", 1, 0, 2'd2, 1, 32'h0000_000C, '0, 64'h8000_0000_1111_1111, 2'b00, 0, 0, 0);
        chk("lwu64_hi.rdata", r_rdata, 64'h0000_0000_8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck handshake still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
